pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed-width inter-stage latches between decode, execute, memory and write-back. It carries an arbitrary-width payload with a valid/ready handshake. An optional skid entry gives full throughput with a registered ready. It also provides synchronous flush (branch/exception kill) and a saturating stall counter for performance monitoring. One instance sits between each pair of adjacent CPU stages.

## Interface
Parameters:
- DW, 32: payload width in bits; legal range 1..1024.
- SKID, 1: 1 = two-entry (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.
- CLEAR_ON_FLUSH, 1: 1 = payload registers forced to 0 on flush; 0 = payload registers hold their value.
- CW, 16: stall counter width.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous and active-low. Asserting rst (low) resets the block immediately; release is synchronised externally.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream has a beat.
- in_ready  output  1  stage accepts a beat this cycle.
- in_data  input  DW  upstream payload.
- out_valid  output  1  out_data holds a beat.
- out_ready  input  1  downstream consumes the beat this cycle.
- out_data  output  DW  payload; driven directly from the main register.
- occupancy  output  2  number of entries held (0..2).
- stall_clr  input  1  synchronous clear of stall_cnt.
- stall_cnt  output  CW  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- State machine for SKID=1, with states EMPTY, ONE, FULL.
  - EMPTY:
    - push → ONE, main ← in_data.
  - ONE:
    - push & !pop → FULL, skid ← in_data.
    - push & pop → ONE, main ← in_data.
    - pop & !push → EMPTY.
  - FULL:
    - pop → ONE, main ← skid.
    - otherwise hold FULL.
  - Outputs: in_ready is registered, = (next state ≠ FULL). out_valid = (state ≠ EMPTY).
- SKID=0:
  - Only EMPTY and ONE exist; the skid register is not built.
  - in_ready = !out_valid | out_ready (combinational).
  - occupancy never exceeds 1.
- Flush:
  - flush=1 has top priority: next state is EMPTY and in_ready goes to 1.
  - Any push in the flush cycle is discarded.
  - A pop in the flush cycle still completes, since downstream samples the current out_data.
  - If CLEAR_ON_FLUSH=1, main and skid are set to 0.
- occupancy: 0 in EMPTY, 1 in ONE, 2 in FULL.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CW−1 and never wraps.
  - stall_clr=1 loads 0; when stall_clr and a stall coincide, the clear wins.
  - flush does not affect stall_cnt.
- Data order is strictly FIFO. No beat is duplicated or lost except by flush.

## Timing
- Reset values: out_valid=0, in_ready=1, out_data=0, occupancy=0, stall_cnt=0; internal state is EMPTY and skid=0.
- Reset mid-transfer discards all entries asynchronously.
- Latency: a beat pushed in cycle N appears on out_data with out_valid=1 in cycle N+1.
- Throughput is one beat per cycle while out_ready=1, in both SKID modes.
- SKID=1:
  - in_ready falls the cycle after FULL is entered.
  - The upstream beat offered in the cycle ready was high is always captured, with no combinational path from out_ready to in_ready.
- out_data and out_valid are held stable while out_valid=1 and out_ready=0.

## Test plan
- Reset and stream: hold rst low, then release, with in_valid=1, data 0x1,0x2,0x3… and out_ready=1. Required: out_valid and in_ready held at 0/1 during reset; after release out_data = 0x1,0x2,0x3 on consecutive cycles, one cycle after each push; occupancy=1 throughout.
- Backpressure (SKID=1): push 0xA, 0xB, 0xC with out_ready=0. Required: 0xA and 0xB held, occupancy=2, in_ready=0, 0xC not accepted until ready returns. After out_ready=1 the output order is 0xA, 0xB, 0xC, with stall_cnt=number of stalled cycles.
- Flush while FULL with a simultaneous push of 0xD. Required: next cycle out_valid=0, occupancy=0, in_ready=1, out_data=0 (CLEAR_ON_FLUSH=1), and 0xD never emitted.
- SKID=0 with out_ready toggling 1,0,1,0. Required: in_ready equals !out_valid|out_ready every cycle, occupancy≤1, no beat lost or duplicated.
- Counter saturation with CW=4: stall for 20 cycles. Required: stall_cnt=15. Then stall_clr together with a stall gives stall_cnt=0.
- Asynchronous reset asserted mid-cycle while FULL. Required: outputs take their reset values before the next clock edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating stall counter.
module pipe_stage_reg #(
    parameter int DW             = 32,
    parameter int SKID           = 1,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CW             = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    occupancy,
    input  logic          stall_clr,
    output logic [CW-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] main_q;
    logic [DW-1:0] main_nxt;
    logic [DW-1:0] skid_q;
    logic          push;
    logic          pop;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        unique case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    main_nxt  = in_data;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    // Only reachable with a skid entry; without one in_ready is low here.
                    if (SKID != 0) begin
                        state_nxt = FULL;
                    end
                end else if (push && pop) begin
                    main_nxt = in_data;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt = ONE;
                    main_nxt  = skid_q;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
        if (flush) begin
            state_nxt = EMPTY;
            if (CLEAR_ON_FLUSH != 0) begin
                main_nxt = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: the payload register is reset because out_data must read 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= EMPTY;
            main_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic ready_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    skid_q <= '0;
                end else if (flush) begin
                    if (CLEAR_ON_FLUSH != 0) begin
                        skid_q <= '0;
                    end
                end else if (state == ONE && push && !pop) begin
                    skid_q <= in_data;
                end
            end

            // Registered ready: no combinational path from out_ready to in_ready.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (state_nxt != FULL);
                end
            end

            assign in_ready = ready_q;
        end else begin : g_no_skid
            assign skid_q   = '0;
            assign in_ready = !out_valid | out_ready;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid instance, no-skid instance and a
// narrow-counter instance sharing one clock and reset.
module tb_pipe_stage_reg;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Instance A: SKID=1, CLEAR_ON_FLUSH=1, CW=16
    logic          a_flush, a_iv, a_ir, a_ov, a_or, a_clr;
    logic [DW-1:0] a_d, a_q;
    logic [1:0]    a_occ;
    logic [15:0]   a_cnt;

    // Instance B: SKID=0
    logic          b_flush, b_iv, b_ir, b_ov, b_or, b_clr;
    logic [DW-1:0] b_d, b_q;
    logic [1:0]    b_occ;
    logic [15:0]   b_cnt;

    // Instance C: SKID=1, CW=4
    logic          c_flush, c_iv, c_ir, c_ov, c_or, c_clr;
    logic [DW-1:0] c_d, c_q;
    logic [1:0]    c_occ;
    logic [3:0]    c_cnt;

    pipe_stage_reg #(.DW(DW), .SKID(1), .CLEAR_ON_FLUSH(1), .CW(16)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_d), .out_valid(a_ov), .out_ready(a_or), .out_data(a_q),
        .occupancy(a_occ), .stall_clr(a_clr), .stall_cnt(a_cnt)
    );

    pipe_stage_reg #(.DW(DW), .SKID(0), .CLEAR_ON_FLUSH(1), .CW(16)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_d), .out_valid(b_ov), .out_ready(b_or), .out_data(b_q),
        .occupancy(b_occ), .stall_clr(b_clr), .stall_cnt(b_cnt)
    );

    pipe_stage_reg #(.DW(DW), .SKID(1), .CLEAR_ON_FLUSH(1), .CW(4)) u_c (
        .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_iv), .in_ready(c_ir),
        .in_data(c_d), .out_valid(c_ov), .out_ready(c_or), .out_data(c_q),
        .occupancy(c_occ), .stall_clr(c_clr), .stall_cnt(c_cnt)
    );

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        clr;
        logic        e_ov;
        logic [31:0] e_data;
        logic        e_ir;
        logic [1:0]  e_occ;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] nd;
        logic        m_v;
        logic [31:0] m_d;
        logic        exp_rdy;
        logic        m_push;
        logic        m_pop;
        logic        pat [12];

        //            iv     d       or     fl     clr    ov     data    ir     occ    cnt
        vecs[0]  = '{1'b1, 32'h01, 1'b1, 1'b0, 1'b0, 1'b1, 32'h01, 1'b1, 2'd1, 16'd0};
        vecs[1]  = '{1'b1, 32'h02, 1'b1, 1'b0, 1'b0, 1'b1, 32'h02, 1'b1, 2'd1, 16'd0};
        vecs[2]  = '{1'b1, 32'h03, 1'b1, 1'b0, 1'b0, 1'b1, 32'h03, 1'b1, 2'd1, 16'd0};
        vecs[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h03, 1'b1, 2'd0, 16'd0};
        vecs[4]  = '{1'b1, 32'h0A, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b1, 2'd1, 16'd0};
        vecs[5]  = '{1'b1, 32'h0B, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b0, 2'd2, 16'd1};
        vecs[6]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b0, 2'd2, 16'd2};
        vecs[7]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0A, 1'b0, 2'd2, 16'd3};
        vecs[8]  = '{1'b1, 32'h0C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0B, 1'b1, 2'd1, 16'd3};
        vecs[9]  = '{1'b1, 32'h0C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 2'd1, 16'd3};
        vecs[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0C, 1'b1, 2'd0, 16'd3};
        vecs[11] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b1, 2'd1, 16'd3};
        vecs[12] = '{1'b1, 32'h12, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2, 16'd4};
        vecs[13] = '{1'b1, 32'h0D, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 2'd0, 16'd5};
        vecs[14] = '{1'b1, 32'h21, 1'b1, 1'b0, 1'b0, 1'b1, 32'h21, 1'b1, 2'd1, 16'd5};
        vecs[15] = '{1'b1, 32'h0D, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 2'd0, 16'd6};
        vecs[16] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 2'd0, 16'd6};
        vecs[17] = '{1'b1, 32'h31, 1'b0, 1'b0, 1'b0, 1'b1, 32'h31, 1'b1, 2'd1, 16'd6};
        vecs[18] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h31, 1'b1, 2'd1, 16'd0};
        vecs[19] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'h31, 1'b1, 2'd1, 16'd1};
        vecs[20] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h31, 1'b1, 2'd0, 16'd1};

        a_flush = 0; a_iv = 1; a_d = 32'h0; a_or = 1; a_clr = 0;
        b_flush = 0; b_iv = 0; b_d = 32'h0; b_or = 0; b_clr = 0;
        c_flush = 0; c_iv = 0; c_d = 32'h0; c_or = 0; c_clr = 0;

        // Reset held with upstream offering a beat.
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_ov",  a_ov,  0);
        check("rst_a_ir",  a_ir,  1);
        check("rst_a_q",   a_q,   0);
        check("rst_a_occ", a_occ, 0);
        check("rst_a_cnt", a_cnt, 0);
        check("rst_b_ov",  b_ov,  0);
        check("rst_b_occ", b_occ, 0);
        check("rst_c_cnt", c_cnt, 0);

        rst = 1'b1;
        for (int i = 0; i < NV; i++) begin
            a_iv = vecs[i].iv; a_d = vecs[i].d; a_or = vecs[i].ordy;
            a_flush = vecs[i].fl; a_clr = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), a_ov,  vecs[i].e_ov);
            check($sformatf("v%0d_out_data",  i), a_q,   vecs[i].e_data);
            check($sformatf("v%0d_in_ready",  i), a_ir,  vecs[i].e_ir);
            check($sformatf("v%0d_occupancy", i), a_occ, vecs[i].e_occ);
            check($sformatf("v%0d_stall_cnt", i), a_cnt, vecs[i].e_cnt);
        end
        a_iv = 0; a_or = 1; a_flush = 0; a_clr = 0;

        // SKID=0: full-rate stream, then out_ready toggling, against a one-entry model.
        pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        nd  = 32'h41;
        m_v = 1'b0;
        m_d = 32'h0;
        for (int k = 0; k < 12; k++) begin
            b_iv = 1'b1; b_d = nd; b_or = pat[k];
            #1;
            exp_rdy = !m_v | pat[k];
            check($sformatf("ns%0d_in_ready", k), b_ir, exp_rdy);
            m_push = exp_rdy;
            m_pop  = m_v & pat[k];
            @(posedge clk);
            #1;
            if (m_push) begin
                m_v = 1'b1;
                m_d = nd;
                nd  = nd + 1;
            end else if (m_pop) begin
                m_v = 1'b0;
            end
            check($sformatf("ns%0d_out_valid", k), b_ov,  m_v);
            check($sformatf("ns%0d_out_data",  k), b_q,   m_d);
            check($sformatf("ns%0d_occupancy", k), b_occ, {1'b0, m_v});
        end
        b_iv = 0; b_or = 1;

        // CW=4 counter: 20 stalled cycles saturate at 15, clear beats a coinciding stall.
        c_iv = 1; c_d = 32'h55; c_or = 0;
        @(posedge clk);
        #1;
        c_iv = 0;
        repeat (15) @(posedge clk);
        #1;
        check("sat_at_15", c_cnt, 15);
        repeat (5) @(posedge clk);
        #1;
        check("sat_no_wrap", c_cnt, 15);
        check("sat_data_held", c_q, 32'h55);
        c_clr = 1;
        @(posedge clk);
        #1;
        check("sat_clr_wins", c_cnt, 0);
        c_clr = 0;
        @(posedge clk);
        #1;
        check("sat_after_clr", c_cnt, 1);

        // Asynchronous reset while FULL, asserted between clock edges.
        a_iv = 1; a_d = 32'h61; a_or = 0;
        @(posedge clk);
        #1;
        a_d = 32'h62;
        @(posedge clk);
        #1;
        a_iv = 0;
        check("arst_pre_occ", a_occ, 2);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_ov",  a_ov,  0);
        check("arst_ir",  a_ir,  1);
        check("arst_q",   a_q,   0);
        check("arst_occ", a_occ, 0);
        check("arst_cnt", a_cnt, 0);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("arst_post_ov", a_ov, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
